// File: rtl/l1_l2_arbiter_pkg.sv
// Shared arbiter types for the L1->L2 Wishbone port: grant FSM states,
// requester identities and default line geometry.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } requester_t;

  localparam int ARB_ADDR_W = 12;
  localparam int ARB_DATA_W = 128;
  localparam int ARB_SEL_W  = ARB_DATA_W / 8;
  localparam int STAT_W     = 32;

  // Round-robin choice from IDLE: on a tie the requester that was not
  // granted last wins, so the two caches alternate under contention.
  function automatic arb_state_t pick_grant(input logic       req_i,
                                            input logic       req_d,
                                            input requester_t last);
    if (req_i && req_d) return (last == REQ_ICACHE) ? GNT_D : GNT_I;
    if (req_i)          return GNT_I;
    if (req_d)          return GNT_D;
    return IDLE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// 32-bit style saturating event counter used by the arbiter statistics;
// only present when L1_L2_ARB_STATS_EN is defined.
`ifdef L1_L2_ARB_STATS_EN
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule
`endif

// File: rtl/l1_l2_arbiter.sv
// Round-robin Wishbone arbiter sharing the L2 port between icache and dcache.
// Define L1_L2_ARB_STATS_EN to add grant/conflict statistics counters.
module l1_l2_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int SEL_W  = ARB_SEL_W
) (
  input  logic              CLK,
  input  logic              RST_N,

  input  logic              i_CYC,
  input  logic              i_STB,
  input  logic              i_WE,
  input  logic [SEL_W-1:0]  i_SEL,
  input  logic [ADDR_W-1:0] i_ADR,
  input  logic [DATA_W-1:0] i_DAT_M,
  output logic [DATA_W-1:0] i_DAT_S,
  output logic              i_ACK,
  output logic              i_RTY,

  input  logic              d_CYC,
  input  logic              d_STB,
  input  logic              d_WE,
  input  logic [SEL_W-1:0]  d_SEL,
  input  logic [ADDR_W-1:0] d_ADR,
  input  logic [DATA_W-1:0] d_DAT_M,
  output logic [DATA_W-1:0] d_DAT_S,
  output logic              d_ACK,
  output logic              d_RTY,

  output logic              m_CYC,
  output logic              m_STB,
  output logic              m_WE,
  output logic [SEL_W-1:0]  m_SEL,
  output logic [ADDR_W-1:0] m_ADR,
  output logic [DATA_W-1:0] m_DAT_M,
  input  logic [DATA_W-1:0] m_DAT_S,
  input  logic              m_ACK,
  input  logic              m_RTY
`ifdef L1_L2_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] i_grant_cnt,
  output logic [STAT_W-1:0] d_grant_cnt,
  output logic [STAT_W-1:0] conflict_cnt
`endif
);

  logic       req_i;
  logic       req_d;
  arb_state_t state;
  arb_state_t state_nxt;
  requester_t last_grant;
  logic       enter_gnt_i;
  logic       enter_gnt_d;

  assign req_i = i_CYC & i_STB;
  assign req_d = d_CYC & d_STB;

  // A grant ends on ACK, RTY or the owner dropping CYC; IDLE always
  // separates two grants so every transfer sees one arbitration cycle.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = pick_grant(req_i, req_d, last_grant);
      GNT_I:   state_nxt = (m_ACK || m_RTY || !i_CYC) ? IDLE : GNT_I;
      GNT_D:   state_nxt = (m_ACK || m_RTY || !d_CYC) ? IDLE : GNT_D;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_gnt_i = (state == IDLE) && (state_nxt == GNT_I);
  assign enter_gnt_d = (state == IDLE) && (state_nxt == GNT_D);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      last_grant <= REQ_ICACHE;
    end else begin
      state <= state_nxt;
      if (enter_gnt_i) last_grant <= REQ_ICACHE;
      if (enter_gnt_d) last_grant <= REQ_DCACHE;
    end
  end

  // Bus mux keyed only on the registered state: m_ACK can never reach
  // m_CYC without passing through the state flops.
  always_comb begin
    m_CYC   = 1'b0;
    m_STB   = 1'b0;
    m_WE    = 1'b0;
    m_SEL   = '0;
    m_ADR   = '0;
    m_DAT_M = '0;
    i_ACK   = 1'b0;
    i_RTY   = 1'b0;
    d_ACK   = 1'b0;
    d_RTY   = 1'b0;
    case (state)
      GNT_I: begin
        m_CYC   = i_CYC;
        m_STB   = i_STB;
        m_WE    = i_WE;
        m_SEL   = i_SEL;
        m_ADR   = i_ADR;
        m_DAT_M = i_DAT_M;
        i_ACK   = m_ACK;
        i_RTY   = m_RTY;
      end
      GNT_D: begin
        m_CYC   = d_CYC;
        m_STB   = d_STB;
        m_WE    = d_WE;
        m_SEL   = d_SEL;
        m_ADR   = d_ADR;
        m_DAT_M = d_DAT_M;
        d_ACK   = m_ACK;
        d_RTY   = m_RTY;
      end
      default: ;
    endcase
  end

  assign i_DAT_S = m_DAT_S;
  assign d_DAT_S = m_DAT_S;

`ifdef L1_L2_ARB_STATS_EN
  logic conflict;
  assign conflict = req_i & req_d;

  sat_counter #(.W(STAT_W)) u_i_grant_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (enter_gnt_i),
    .count (i_grant_cnt)
  );

  sat_counter #(.W(STAT_W)) u_d_grant_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (enter_gnt_d),
    .count (d_grant_cnt)
  );

  sat_counter #(.W(STAT_W)) u_conflict_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .inc   (conflict),
    .count (conflict_cnt)
  );
`endif

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Self-checking bench for l1_l2_arbiter: directed scenarios plus randomized
// traffic against a transaction-level ownership model.
module tb_l1_l2_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 128;
  localparam int SEL_W  = 16;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              i_CYC, i_STB, i_WE, i_ACK, i_RTY;
  logic [SEL_W-1:0]  i_SEL;
  logic [ADDR_W-1:0] i_ADR;
  logic [DATA_W-1:0] i_DAT_M, i_DAT_S;
  logic              d_CYC, d_STB, d_WE, d_ACK, d_RTY;
  logic [SEL_W-1:0]  d_SEL;
  logic [ADDR_W-1:0] d_ADR;
  logic [DATA_W-1:0] d_DAT_M, d_DAT_S;
  logic              m_CYC, m_STB, m_WE, m_ACK, m_RTY;
  logic [SEL_W-1:0]  m_SEL;
  logic [ADDR_W-1:0] m_ADR;
  logic [DATA_W-1:0] m_DAT_M, m_DAT_S;
`ifdef L1_L2_ARB_STATS_EN
  logic [31:0] i_grant_cnt, d_grant_cnt, conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  l1_l2_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .i_CYC(i_CYC), .i_STB(i_STB), .i_WE(i_WE), .i_SEL(i_SEL), .i_ADR(i_ADR),
    .i_DAT_M(i_DAT_M), .i_DAT_S(i_DAT_S), .i_ACK(i_ACK), .i_RTY(i_RTY),
    .d_CYC(d_CYC), .d_STB(d_STB), .d_WE(d_WE), .d_SEL(d_SEL), .d_ADR(d_ADR),
    .d_DAT_M(d_DAT_M), .d_DAT_S(d_DAT_S), .d_ACK(d_ACK), .d_RTY(d_RTY),
    .m_CYC(m_CYC), .m_STB(m_STB), .m_WE(m_WE), .m_SEL(m_SEL), .m_ADR(m_ADR),
    .m_DAT_M(m_DAT_M), .m_DAT_S(m_DAT_S), .m_ACK(m_ACK), .m_RTY(m_RTY)
`ifdef L1_L2_ARB_STATS_EN
    , .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    i_CYC = 0; i_STB = 0; i_WE = 0; i_SEL = '0; i_ADR = '0; i_DAT_M = '0;
    d_CYC = 0; d_STB = 0; d_WE = 0; d_SEL = '0; d_ADR = '0; d_DAT_M = '0;
    m_ACK = 0; m_RTY = 0; m_DAT_S = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 0;
    idle_inputs();
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST_N = 0;
    i_CYC = 1; i_STB = 1; d_CYC = 1; d_STB = 1; m_ACK = 1; m_RTY = 1;
    #1;
    checks++;
    if ({m_CYC, m_STB, i_ACK, i_RTY, d_ACK, d_RTY} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000", {m_CYC, m_STB, i_ACK, i_RTY, d_ACK, d_RTY});
    end
    step();
    checks++;
    if ({m_CYC, m_STB, i_ACK, d_ACK} !== 4'b0) begin
      errors++;
      $display("FAIL reset_held: got %b expected 0000", {m_CYC, m_STB, i_ACK, d_ACK});
    end
`ifdef L1_L2_ARB_STATS_EN
    checks++;
    if ({i_grant_cnt, d_grant_cnt, conflict_cnt} !== 96'b0) begin
      errors++;
      $display("FAIL reset_counters: got %h %h %h expected 0", i_grant_cnt, d_grant_cnt, conflict_cnt);
    end
`endif
    idle_inputs();
    @(negedge CLK);
    RST_N = 1;
  endtask

  task automatic test_basic_read();
    do_reset();
    step();
    i_CYC = 1; i_STB = 1; i_WE = 0; i_SEL = '1; i_ADR = 12'h123;
    #1;
    checks++;
    if (m_CYC !== 1'b0) begin
      errors++;
      $display("FAIL grant_latency: m_CYC got %b expected 0", m_CYC);
    end
    step();
    checks++;
    if ({m_CYC, m_STB, m_ADR} !== {2'b11, 12'h123}) begin
      errors++;
      $display("FAIL read_grant: got cyc/stb %b%b adr %h expected 11 123", m_CYC, m_STB, m_ADR);
    end
    m_DAT_S = {16{8'hA5}};
    m_ACK = 1;
    #1;
    checks++;
    if ({i_ACK, d_ACK, i_DAT_S} !== {2'b10, {16{8'hA5}}}) begin
      errors++;
      $display("FAIL read_ack: got i_ack %b d_ack %b data %h expected 1 0 a5..", i_ACK, d_ACK, i_DAT_S);
    end
    step();
    m_ACK = 0;
    #1;
    checks++;
    if ({m_CYC, i_ACK} !== 2'b00) begin
      errors++;
      $display("FAIL read_idle_after_ack: got cyc %b ack %b expected 0 0", m_CYC, i_ACK);
    end
    idle_inputs();
  endtask

  task automatic test_tie();
    do_reset();
    step();
    i_CYC = 1; i_STB = 1; i_ADR = 12'h111;
    d_CYC = 1; d_STB = 1; d_ADR = 12'h040;
    step();
    checks++;
    if ({m_CYC, m_ADR} !== {1'b1, 12'h040}) begin
      errors++;
      $display("FAIL tie_first_dcache: got cyc %b adr %h expected 1 040", m_CYC, m_ADR);
    end
    m_ACK = 1;
    #1;
    checks++;
    if ({d_ACK, i_ACK} !== 2'b10) begin
      errors++;
      $display("FAIL tie_d_ack: got d %b i %b expected 1 0", d_ACK, i_ACK);
    end
    step();
    m_ACK = 0; d_CYC = 0; d_STB = 0;
    #1;
    checks++;
    if (m_CYC !== 1'b0) begin
      errors++;
      $display("FAIL tie_idle_gap: m_CYC got %b expected 0", m_CYC);
    end
    step();
    checks++;
    if ({m_CYC, m_ADR} !== {1'b1, 12'h111}) begin
      errors++;
      $display("FAIL tie_then_icache: got cyc %b adr %h expected 1 111", m_CYC, m_ADR);
    end
    d_CYC = 1; d_STB = 1; m_ACK = 1;
    #1;
    checks++;
    if ({i_ACK, d_ACK} !== 2'b10) begin
      errors++;
      $display("FAIL tie_i_ack: got i %b d %b expected 1 0", i_ACK, d_ACK);
    end
    step();
    m_ACK = 0;
    step();
    checks++;
    if ({m_CYC, m_ADR} !== {1'b1, 12'h040}) begin
      errors++;
      $display("FAIL tie_alternate_d: got cyc %b adr %h expected 1 040", m_CYC, m_ADR);
    end
    m_ACK = 1;
    step();
    idle_inputs();
  endtask

  task automatic test_dcache_write();
    logic [DATA_W-1:0] wdata;
    wdata = 128'h0123456789ABCDEF_FEDCBA9876543210;
    do_reset();
    step();
    i_CYC = 1; i_STB = 1; i_ADR = 12'h222;
    d_CYC = 1; d_STB = 1; d_WE = 1; d_SEL = 16'hFFFF; d_ADR = 12'h0AB; d_DAT_M = wdata;
    step();
    checks++;
    if ({m_WE, m_SEL, m_ADR, m_DAT_M} !== {1'b1, 16'hFFFF, 12'h0AB, wdata}) begin
      errors++;
      $display("FAIL write_bus: got we %b sel %h adr %h dat %h", m_WE, m_SEL, m_ADR, m_DAT_M);
    end
    for (int k = 0; k < 2; k++) begin
      if (k == 1) m_ACK = 1;
      #1;
      checks++;
      if ({i_ACK, d_ACK} !== {1'b0, (k == 1)}) begin
        errors++;
        $display("FAIL write_ack_%0d: got i %b d %b expected 0 %0d", k, i_ACK, d_ACK, k);
      end
      step();
    end
    m_ACK = 0; d_CYC = 0; d_STB = 0; d_WE = 0;
    #1;
    checks++;
    if (i_ACK !== 1'b0) begin
      errors++;
      $display("FAIL write_i_quiet: i_ACK got %b expected 0", i_ACK);
    end
    idle_inputs();
  endtask

  task automatic test_abort();
    do_reset();
    step();
    i_CYC = 1; i_STB = 1; i_ADR = 12'h0F0;
    step();
    step();
    i_CYC = 0; i_STB = 0;
    #1;
    checks++;
    if (m_CYC !== 1'b0) begin
      errors++;
      $display("FAIL abort_cyc_drop: m_CYC got %b expected 0", m_CYC);
    end
    step();
    m_ACK = 1;
    #1;
    checks++;
    if ({i_ACK, d_ACK} !== 2'b00) begin
      errors++;
      $display("FAIL abort_late_ack: got i %b d %b expected 0 0", i_ACK, d_ACK);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_retry();
    do_reset();
    step();
    d_CYC = 1; d_STB = 1; d_ADR = 12'h055;
    step();
    i_CYC = 1; i_STB = 1; i_ADR = 12'h0AA;
    m_RTY = 1;
    #1;
    checks++;
    if ({d_RTY, d_ACK, i_RTY, m_ADR} !== {3'b100, 12'h055}) begin
      errors++;
      $display("FAIL retry_forward: got d_rty %b d_ack %b i_rty %b adr %h", d_RTY, d_ACK, i_RTY, m_ADR);
    end
    step();
    m_RTY = 0;
    #1;
    checks++;
    if ({d_RTY, m_CYC} !== 2'b00) begin
      errors++;
      $display("FAIL retry_idle: got d_rty %b cyc %b expected 0 0", d_RTY, m_CYC);
    end
    step();
    checks++;
    if ({m_CYC, m_ADR} !== {1'b1, 12'h0AA}) begin
      errors++;
      $display("FAIL retry_next_icache: got cyc %b adr %h expected 1 0aa", m_CYC, m_ADR);
    end
    m_ACK = 1;
    step();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    step();
    i_CYC = 1; i_STB = 1; i_ADR = 12'h321;
    step();
    #2;
    RST_N = 0;
    m_ACK = 1; m_RTY = 1;
    #1;
    checks++;
    if ({m_CYC, m_STB, i_ACK, i_RTY, d_ACK, d_RTY} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected 000000", {m_CYC, m_STB, i_ACK, i_RTY, d_ACK, d_RTY});
    end
    idle_inputs();
    @(negedge CLK);
    RST_N = 1;
`ifdef L1_L2_ARB_STATS_EN
    step();
    i_CYC = 1; i_STB = 1; d_CYC = 1; d_STB = 1;
    step();
    step();
    step();
    idle_inputs();
    #1;
    checks++;
    if ({conflict_cnt, d_grant_cnt, i_grant_cnt} !== {32'd3, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL stats_conflict: got c %0d d %0d i %0d expected 3 1 0", conflict_cnt, d_grant_cnt, i_grant_cnt);
    end
    RST_N = 0;
    #1;
    checks++;
    if ({conflict_cnt, d_grant_cnt, i_grant_cnt} !== 96'b0) begin
      errors++;
      $display("FAIL stats_reset: got c %0d d %0d i %0d expected 0", conflict_cnt, d_grant_cnt, i_grant_cnt);
    end
    @(negedge CLK);
    RST_N = 1;
`endif
  endtask

  // Model: who owns the L2 port (0 none, 1 icache, 2 dcache) and who won last.
  task automatic test_random();
    int owner, last;
    int exp_ig, exp_dg, exp_cf;
    logic ri, rd, term;
    logic [2+SEL_W+ADDR_W+DATA_W:0] exp_bus;
    logic [3:0] exp_term;
    owner = 0; last = 1; exp_ig = 0; exp_dg = 0; exp_cf = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step();
      i_CYC = ($urandom % 4) != 0;
      i_STB = ($urandom % 4) != 0;
      i_WE = $urandom % 2;
      i_SEL = SEL_W'($urandom);
      i_ADR = ADDR_W'($urandom);
      i_DAT_M = {$urandom, $urandom, $urandom, $urandom};
      d_CYC = ($urandom % 4) != 0;
      d_STB = ($urandom % 4) != 0;
      d_WE = $urandom % 2;
      d_SEL = SEL_W'($urandom);
      d_ADR = ADDR_W'($urandom);
      d_DAT_M = {$urandom, $urandom, $urandom, $urandom};
      m_ACK = ($urandom % 4) == 0;
      m_RTY = ($urandom % 8) == 0;
      m_DAT_S = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (owner == 1) begin
        exp_bus = {i_CYC, i_STB, i_WE, i_SEL, i_ADR, i_DAT_M};
        exp_term = {m_ACK, m_RTY, 2'b00};
      end else if (owner == 2) begin
        exp_bus = {d_CYC, d_STB, d_WE, d_SEL, d_ADR, d_DAT_M};
        exp_term = {2'b00, m_ACK, m_RTY};
      end else begin
        exp_bus = '0;
        exp_term = 4'b0;
      end
      checks++;
      if ({m_CYC, m_STB, m_WE, m_SEL, m_ADR, m_DAT_M} !== exp_bus) begin
        errors++;
        $display("FAIL rand_bus[%0d]: got cyc %b adr %h owner-model %0d expected cyc %b", n, m_CYC, m_ADR, owner, exp_bus[2+SEL_W+ADDR_W+DATA_W]);
      end
      checks++;
      if ({i_ACK, i_RTY, d_ACK, d_RTY} !== exp_term) begin
        errors++;
        $display("FAIL rand_term[%0d]: got %b expected %b", n, {i_ACK, i_RTY, d_ACK, d_RTY}, exp_term);
      end
      checks++;
      if ({i_DAT_S, d_DAT_S} !== {m_DAT_S, m_DAT_S}) begin
        errors++;
        $display("FAIL rand_rdata[%0d]: got %h %h expected %h", n, i_DAT_S, d_DAT_S, m_DAT_S);
      end
`ifdef L1_L2_ARB_STATS_EN
      checks++;
      if ({i_grant_cnt, d_grant_cnt, conflict_cnt} !== {32'(exp_ig), 32'(exp_dg), 32'(exp_cf)}) begin
        errors++;
        $display("FAIL rand_stats[%0d]: got %0d %0d %0d expected %0d %0d %0d", n, i_grant_cnt, d_grant_cnt, conflict_cnt, exp_ig, exp_dg, exp_cf);
      end
`endif
      ri = i_CYC & i_STB;
      rd = d_CYC & d_STB;
      if (ri && rd) exp_cf++;
      if (owner == 0) begin
        if (ri && rd) owner = (last == 1) ? 2 : 1;
        else if (ri) owner = 1;
        else if (rd) owner = 2;
        if (owner != 0) last = owner;
        if (owner == 1) exp_ig++;
        if (owner == 2) exp_dg++;
      end else begin
        term = m_ACK || m_RTY || ((owner == 1) ? !i_CYC : !d_CYC);
        if (term) owner = 0;
      end
    end
    step();
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_basic_read();
    test_tie();
    test_dcache_write();
    test_abort();
    test_retry();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_l2_arbiter.md
Name: l1_l2_arbiter

Overview:
- Two-requester Wishbone arbiter that shares the single L1->L2 port between the instruction cache and the data cache.
- Sits between the two L1 cache memory-side ports and the L2 cache CPU-side port.
- Round-robin grant with a registered grant FSM; the granted requester's bus is muxed through to L2 until the transfer terminates.

Parameters:
- ADDR_W, 12, line address width (byte address bits 15:4)
- DATA_W, 128, line data width
- SEL_W, 16, byte-select width (DATA_W/8)

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- i_CYC, i_STB, i_WE  in  1 each  icache master controls
- i_SEL  in  SEL_W  icache byte select
- i_ADR  in  ADDR_W  icache line address
- i_DAT_M  in  DATA_W  icache write data
- i_DAT_S  out  DATA_W  read data to icache
- i_ACK, i_RTY  out  1 each  icache termination
- d_CYC, d_STB, d_WE, d_SEL, d_ADR, d_DAT_M, d_DAT_S, d_ACK, d_RTY  (same directions/widths)  dcache side
- m_CYC, m_STB, m_WE  out  1 each  to L2
- m_SEL  out  SEL_W  to L2
- m_ADR  out  ADDR_W  to L2
- m_DAT_M  out  DATA_W  write data to L2
- m_DAT_S  in  DATA_W  read data from L2
- m_ACK, m_RTY  in  1 each  L2 termination

Behaviour:
- Reset is asynchronous and active-low. While RST_N=0: state=IDLE, last_grant=ICACHE (dcache wins the first tie), and m_CYC=m_STB=i_ACK=i_RTY=d_ACK=d_RTY=0.
- Request condition: req_x = x_CYC & x_STB.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE transitions:
  - only req_i -> GNT_I; only req_d -> GNT_D.
  - both -> the requester that was not last_grant.
  - Update last_grant on entry to the grant state.
- Grant latency: a request sampled in IDLE at edge N drives m_CYC/m_STB from edge N+1. Minimum 1 idle cycle before any grant.
- In GNT_x:
  - m_CYC/STB/WE/SEL/ADR/DAT_M = x's signals (combinational mux).
  - x_ACK = m_ACK and x_RTY = m_RTY (combinational).
  - The other requester sees ACK=RTY=0.
- i_DAT_S = d_DAT_S = m_DAT_S (broadcast); valid only with the respective ACK.
- GNT_x -> IDLE on any of:
  - m_ACK=1 (transfer complete).
  - m_RTY=1: transfer terminated; the requester must re-request and re-arbitrates normally.
  - x_CYC=0: requester abort. m_CYC drops in the same cycle; a late m_ACK/m_RTY in IDLE is dropped and never forwarded.
- Back-to-back: after termination the FSM spends one cycle in IDLE. If both are then requesting, the other requester is granted (alternation). A lone requester may be re-granted.
- In IDLE: m_CYC=m_STB=m_WE=0; m_SEL, m_ADR and m_DAT_M are don't-care and driven 0.
- Single outstanding transfer; no pipelining and no burst locking.
- Reset mid-transfer: immediate return to IDLE, all termination outputs 0. Any in-flight L2 response is ignored.
- No combinational path from m_ACK to m_CYC other than through the state register.

Optional Feature:
- Macro: L1_L2_ARB_STATS_EN
- Defined:
  - Adds output ports i_grant_cnt, d_grant_cnt and conflict_cnt, each 32-bit saturating (hold at 0xFFFFFFFF).
  - i_grant_cnt / d_grant_cnt increment on each transition into GNT_I / GNT_D.
  - conflict_cnt increments every cycle in which req_i & req_d.
  - All counters reset to 0.
- Undefined: the ports and counters do not exist; arbitration behaviour is identical in both builds.

Decomposition:
- Shared package lc3b_types: arb_state_t enum {IDLE, GNT_I, GNT_D} and requester_t {REQ_ICACHE, REQ_DCACHE}.
- Width constants from the parameters.
- No sub-module for the core. If L1_L2_ARB_STATS_EN is defined, sub-module sat_counter (32-bit saturating increment) is instantiated three times.

Test Plan:
1. After reset, i_CYC=i_STB=1, i_ADR=0x123, i_WE=0 -> m_CYC=1 and m_ADR=0x123 one cycle later. L2 m_ACK with m_DAT_S=0xA5..A5 -> i_ACK=1 same cycle, i_DAT_S=0xA5..A5, d_ACK=0, state IDLE next cycle.
2. Both requesting in the same cycle after reset: d wins (d_ADR=0x040 on m_ADR). After d_ACK, one IDLE cycle, then i granted. After i_ACK with d re-requesting, d granted.
3. Dcache write d_WE=1, d_SEL=0xFFFF, d_DAT_M=0x0123..; i_STB held -> m_WE=1 and m_DAT_M=d data. i_ACK stays 0 throughout.
4. Granted icache drops i_CYC before ACK -> m_CYC=0 that cycle. A late m_ACK produces no i_ACK/d_ACK.
5. m_RTY during d grant -> d_RTY=1 for one cycle, FSM returns to IDLE, the next grant goes to i if pending.
6. RST_N pulsed low mid-transfer -> m_CYC and all ACK/RTY go 0 asynchronously. With L1_L2_ARB_STATS_EN, 3 conflicting cycles give conflict_cnt=3, then reset gives 0.
